// File: rtl/imem_fetch_port.sv
// imem_fetch_port: word-organised instruction store with valid/ready fetch, configurable latency,
// misaligned/out-of-range fault detection and a word-wide load port.
module imem_fetch_port #(
    parameter int          DEPTH       = 64,
    parameter int          AW          = 32,
    parameter int          LATENCY     = 1,
    parameter int          ALIGN_CHECK = 1,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic                     del_clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AW-1:0]            req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic [1:0]               rsp_fault,
    input  logic                     ld_en,
    output logic                     ld_ready,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];
    logic [1:0]  fault;
    logic        accept;

    // Range check uses the whole word index so high address bits never alias into the store.
    always_comb begin
        fault     = (ALIGN_CHECK != 0 && req_addr[1:0] != 2'b00) ? 2'b01 :
                    (req_addr[AW-1:2] >= (AW-2)'(DEPTH))           ? 2'b10 : 2'b00;
        req_ready = (state == IDLE) && !ld_en;
        ld_ready  = (state == IDLE);
        rsp_valid = (state == RESP);
        accept    = req_valid && req_ready;
    end

    always_ff @(posedge del_clk) begin
        if (ld_en && state == IDLE)
            mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge del_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_instr <= 32'd0;
            rsp_fault <= 2'b00;
        end else if (accept) begin
            rsp_fault <= fault;
            rsp_instr <= (fault != 2'b00) ? NOP_WORD : mem[req_addr[IW+1:2]];
            state     <= (LATENCY == 1) ? RESP : WAIT;
            cnt       <= 4'(LATENCY - 1);
        end else if (state == WAIT) begin
            cnt   <= cnt - 4'd1;
            state <= (cnt == 4'd1) ? RESP : WAIT;
        end else if (state == RESP && rsp_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: scoreboard bench; DUT a has LATENCY=1/ALIGN_CHECK=1, DUT b has LATENCY=4/ALIGN_CHECK=0.
module tb_imem_fetch_port;
    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fault;
        int          acc;
    } exp_t;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0 = 32'h00500093, W1 = 32'h00A00113, W2 = 32'h002081B3, W3 = 32'h0000006F;
    localparam logic [31:0] W63 = 32'h13579BDF;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready, ld_en, ld_ready;
    logic [1:0][31:0] req_addr, rsp_instr, ld_data;
    logic [1:0][1:0] rsp_fault;
    logic [1:0][5:0] ld_addr;

    int   checks = 0, failures = 0, cyc = 0;
    exp_t q0[$], q1[$];
    bit   seen[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_fetch_port #(.LATENCY(1), .ALIGN_CHECK(1)) u_a (
        .del_clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_instr(rsp_instr[0]), .rsp_fault(rsp_fault[0]), .ld_en(ld_en[0]),
        .ld_ready(ld_ready[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

    imem_fetch_port #(.LATENCY(4), .ALIGN_CHECK(0)) u_b (
        .del_clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_instr(rsp_instr[1]), .rsp_fault(rsp_fault[1]), .ld_en(ld_en[1]),
        .ld_ready(ld_ready[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

    function automatic int lat(int d);
        return d == 0 ? 1 : 4;
    endfunction

    function automatic int qsize(int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every cycle a response is presented it must match the scoreboard head.
    task automatic mon(int d);
        exp_t e;
        if (!rsp_valid[d]) return;
        if (qsize(d) == 0) begin
            chk($sformatf("stray_rsp_valid_%0d", d), rsp_valid[d], 1'b0);
            return;
        end
        e = (d == 0) ? q0[0] : q1[0];
        chk($sformatf("rsp_instr_%0d", d), rsp_instr[d], e.instr);
        chk($sformatf("rsp_fault_%0d", d), rsp_fault[d], e.fault);
        chk($sformatf("req_ready_in_resp_%0d", d), req_ready[d], 1'b0);
        chk($sformatf("ld_ready_in_resp_%0d", d), ld_ready[d], 1'b0);
        if (!seen[d]) begin
            chk($sformatf("latency_%0d", d), cyc - e.acc + 1, lat(d));
            seen[d] = 1'b1;
        end
        if (rsp_ready[d]) begin
            seen[d] = 1'b0;
            if (d == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic load(int d, logic [5:0] a, logic [31:0] data);
        ld_en[d] = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = data;
        @(negedge clk);
        chk($sformatf("ld_ready_%0d", d), ld_ready[d], 1'b1);
        @(posedge clk);
        #1 ld_en[d] = 1'b0;
    endtask

    task automatic fetch(int d, logic [31:0] addr, logic [31:0] ins, logic [1:0] flt, output int acc);
        exp_t e;
        int n;
        req_valid[d] = 1'b1;
        req_addr[d] = addr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[d] && n < 100);
        chk($sformatf("req_ready_wait_%0d", d), req_ready[d], 1'b1);
        acc = -1;
        if (req_ready[d]) begin
            @(posedge clk);
            #1;
            acc = cyc;
            e.instr = ins;
            e.fault = flt;
            e.acc = acc;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        req_valid[d] = 1'b0;
    endtask

    task automatic drain(int d);
        for (int n = 0; n < 100 && qsize(d) != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk($sformatf("drain_%0d", d), qsize(d), 0);
    endtask

    task automatic fetch_drain(int d, logic [31:0] addr, logic [31:0] ins, logic [1:0] flt);
        int acc;
        fetch(d, addr, ins, flt, acc);
        drain(d);
    endtask

    initial begin
        int acc, prev;
        rst = 1'b1;
        req_valid = '0; rsp_ready = 2'b11; ld_en = '0;
        req_addr = '0; ld_addr = '0; ld_data = '0;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req_ready_%0d", d), req_ready[d], 1'b1);
            chk($sformatf("rst_ld_ready_%0d", d), ld_ready[d], 1'b1);
            chk($sformatf("rst_rsp_valid_%0d", d), rsp_valid[d], 1'b0);
            chk($sformatf("rst_rsp_instr_%0d", d), rsp_instr[d], 32'd0);
            chk($sformatf("rst_rsp_fault_%0d", d), rsp_fault[d], 2'b00);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            load(d, 6'd0, W0); load(d, 6'd1, W1); load(d, 6'd2, W2); load(d, 6'd3, W3);
            load(d, 6'd63, W63);
        end
        // Back-to-back LATENCY=1 fetches: acceptances two edges apart.
        fetch(0, 32'h0, W0, 2'b00, prev);
        fetch(0, 32'h4, W1, 2'b00, acc); chk("turnaround_1", acc - prev, 2); prev = acc;
        fetch(0, 32'h8, W2, 2'b00, acc); chk("turnaround_2", acc - prev, 2); prev = acc;
        fetch(0, 32'hC, W3, 2'b00, acc); chk("turnaround_3", acc - prev, 2);
        drain(0);
        // Stalled response on the long-latency port.
        rsp_ready[1] = 1'b0;
        fetch(1, 32'h4, W1, 2'b00, acc);
        repeat (lat(1) - 1 + 5) @(posedge clk);
        #1 rsp_ready[1] = 1'b1;
        drain(1);
        // Alignment and range boundaries.
        fetch_drain(0, 32'h6, NOP, 2'b01);
        fetch_drain(1, 32'h6, W1, 2'b00);
        fetch_drain(0, 32'hFC, W63, 2'b00);
        fetch_drain(0, 32'h100, NOP, 2'b10);
        fetch_drain(0, 32'h102, NOP, 2'b01);
        fetch_drain(1, 32'h102, NOP, 2'b10);
        fetch_drain(1, 32'hFC, W63, 2'b00);
        fetch_drain(0, 32'h8000_0000, NOP, 2'b10);
        // Load wins over a simultaneous request.
        ld_en[0] = 1'b1; ld_addr[0] = 6'd2; ld_data[0] = 32'hDEADBEEF;
        req_valid[0] = 1'b1; req_addr[0] = 32'h8;
        @(negedge clk);
        chk("ld_prio_req_ready", req_ready[0], 1'b0);
        chk("ld_prio_ld_ready", ld_ready[0], 1'b1);
        @(posedge clk);
        #1 ld_en[0] = 1'b0;
        fetch(0, 32'h8, 32'hDEADBEEF, 2'b00, acc);
        drain(0);
        // Reset while the LATENCY=4 fetch is still waiting.
        fetch(1, 32'h8, W2, 2'b00, acc);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_rsp_valid", rsp_valid[1], 1'b0);
        chk("abort_req_ready", req_ready[1], 1'b1);
        q1.delete();
        seen[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", rsp_valid[1], 1'b0);
            chk("post_rst_req_ready", req_ready[1], 1'b1);
        end
        @(posedge clk);
        #1;
        fetch_drain(1, 32'h8, W2, 2'b00);
        fetch_drain(0, 32'h8, 32'hDEADBEEF, 2'b00);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
